// File: rtl/pixel_frame_buffer.sv
// Double-buffered 7x7 pixel frame assembler: serial valid/ready byte stream in,
// whole frame presented in parallel from a held read bank.
module pixel_frame_buffer #(
    parameter int NUM_PIXELS = 49,
    parameter int PIXEL_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIXEL_W-1:0]            pixel_in,
    input  logic                          pixel_valid,
    input  logic                          pixel_sof,
    output logic                          pixel_ready,
    output logic [NUM_PIXELS*PIXEL_W-1:0] frame_data,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic                          sync_err,
    output logic [15:0]                   frame_count
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_PRESENT = 2'd1,
        S_STALL   = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [IDX_W-1:0]                     wr_idx_q, wr_idx_d;
    logic [NUM_PIXELS-1:0][PIXEL_W-1:0]   wbank_q, wbank_d;
    logic [NUM_PIXELS-1:0][PIXEL_W-1:0]   rbank_q, rbank_d;
    logic                                 frame_valid_q, frame_valid_d;
    logic                                 sync_err_q, sync_err_d;
    logic [15:0]                          frame_count_q, frame_count_d;

    logic                                 accept;
    logic                                 handshake;
    logic                                 last;
    logic [IDX_W-1:0]                     wr_pos;
    logic                                 load_new;
    logic                                 load_held;

    // Ready is forced low during reset so nothing is accepted on the reset edge.
    assign pixel_ready = !rst && (state_q != S_STALL);
    assign accept      = pixel_valid && pixel_ready;
    assign handshake   = frame_valid_q && frame_ready;
    assign wr_pos      = pixel_sof ? '0 : wr_idx_q;
    assign last        = accept && (wr_pos == LAST_IDX);

    always_comb begin
        wbank_d       = wbank_q;
        wr_idx_d      = wr_idx_q;
        sync_err_d    = 1'b0;
        frame_count_d = frame_count_q + 16'(handshake);
        if (accept) begin
            wbank_d[wr_pos] = pixel_in;
            wr_idx_d        = (wr_pos == LAST_IDX) ? '0 : wr_pos + 1'b1;
            sync_err_d      = pixel_sof && (wr_idx_q != '0);
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_valid_d = frame_valid_q;
        load_new      = 1'b0;
        load_held     = 1'b0;
        case (state_q)
            S_FILL: begin
                if (last) begin
                    load_new      = 1'b1;
                    frame_valid_d = 1'b1;
                    state_d       = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (last && handshake) begin
                    load_new = 1'b1;
                end else if (last) begin
                    state_d = S_STALL;
                end else if (handshake) begin
                    frame_valid_d = 1'b0;
                    state_d       = S_FILL;
                end
            end
            S_STALL: begin
                if (handshake) begin
                    load_held = 1'b1;
                    state_d   = S_PRESENT;
                end
            end
            default: begin
                frame_valid_d = 1'b0;
                state_d       = S_FILL;
            end
        endcase
    end

    // A completing pixel lands in the read bank in the same cycle via wbank_d.
    always_comb begin
        rbank_d = rbank_q;
        if (load_new) begin
            rbank_d = wbank_d;
        end else if (load_held) begin
            rbank_d = wbank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FILL;
            wr_idx_q      <= '0;
            wbank_q       <= '0;
            rbank_q       <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            wbank_q       <= wbank_d;
            rbank_q       <= rbank_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_data  = rbank_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer: fill, stall, resync, streaming,
// reset-in-stall and randomised backpressure scenarios.
module tb_pixel_frame_buffer;

    localparam int NP = 49;
    localparam int PW = 8;
    localparam int FW = NP * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pixel_in;
    logic          pixel_valid;
    logic          pixel_sof;
    logic          pixel_ready;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic          sync_err;
    logic [15:0]   frame_count;

    int n_cmp = 0;
    int n_err = 0;

    pixel_frame_buffer #(.NUM_PIXELS(NP), .PIXEL_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_sof   (pixel_sof),
        .pixel_ready (pixel_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sync_err    (sync_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        pixel_in    = d;
        pixel_sof   = sof;
        pixel_valid = 1'b1;
        step();
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    task automatic send_ramp(input logic [7:0] base);
        for (int k = 0; k < NP; k++) send(base + 8'(k), k == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [FW-1:0] frame_ramp(input logic [7:0] base);
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < NP; k++) r[k*PW +: PW] = base + 8'(k);
        return r;
    endfunction

    function automatic logic [FW-1:0] frame_rand(input int f);
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < NP; k++) r[k*PW +: PW] = 8'((f * 37 + k * 3 + 5) & 255);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; pixel_valid = 1'b0; pixel_sof = 1'b0; pixel_in = '0; frame_ready = 1'b0;
        step();
        step();
        n_cmp++;
        if (pixel_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst got=%b exp=0", pixel_ready); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got=%b exp=1", pixel_ready); end
        n_cmp++;
        if (frame_valid !== 1'b0 || sync_err !== 1'b0 || frame_count !== 16'd0) begin
            n_err++; $display("FAIL reset_outputs fv=%b se=%b cnt=%0d exp 0/0/0", frame_valid, sync_err, frame_count);
        end
        n_cmp++;
        if (frame_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", frame_data); end
    endtask

    task automatic test_single_frame();
        frame_ready = 1'b1;
        for (int k = 0; k < NP; k++) begin
            send(8'(k), k == 0);
            if (k == 0) begin
                n_cmp++;
                if (sync_err !== 1'b0) begin n_err++; $display("FAIL sof_at_zero_err got=%b exp=0", sync_err); end
            end
            if (k == NP - 2) begin
                n_cmp++;
                if (frame_valid !== 1'b0) begin n_err++; $display("FAIL single_early_fv got=%b exp=0", frame_valid); end
            end
        end
        n_cmp++;
        if (frame_valid !== 1'b1) begin n_err++; $display("FAIL single_fv got=%b exp=1", frame_valid); end
        n_cmp++;
        if (frame_data[7:0] !== 8'h00 || frame_data[391:384] !== 8'h30) begin
            n_err++; $display("FAIL single_ends p0=%h p48=%h exp 00/30", frame_data[7:0], frame_data[391:384]);
        end
        n_cmp++;
        if (frame_data !== frame_ramp(8'h00)) begin n_err++; $display("FAIL single_data got=%h exp=%h", frame_data, frame_ramp(8'h00)); end
        step();
        n_cmp++;
        if (frame_count !== 16'd1 || frame_valid !== 1'b0) begin
            n_err++; $display("FAIL single_count cnt=%0d fv=%b exp 1/0", frame_count, frame_valid);
        end
        frame_ready = 1'b0;
    endtask

    task automatic test_stall();
        frame_ready = 1'b0;
        send_ramp(8'h10);
        n_cmp++;
        if (frame_valid !== 1'b1) begin n_err++; $display("FAIL stall_fv_a got=%b exp=1", frame_valid); end
        send_ramp(8'h80);
        n_cmp++;
        if (pixel_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got=%b exp=0", pixel_ready); end
        step(); step(); step();
        n_cmp++;
        if (frame_data !== frame_ramp(8'h10) || frame_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_hold_a fv=%b got=%h exp=%h", frame_valid, frame_data, frame_ramp(8'h10));
        end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        n_cmp++;
        if (frame_data !== frame_ramp(8'h80)) begin n_err++; $display("FAIL stall_release_b got=%h exp=%h", frame_data, frame_ramp(8'h80)); end
        n_cmp++;
        if (frame_valid !== 1'b1 || pixel_ready !== 1'b1 || frame_count !== 16'd2) begin
            n_err++; $display("FAIL stall_release_flags fv=%b rdy=%b cnt=%0d exp 1/1/2", frame_valid, pixel_ready, frame_count);
        end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        n_cmp++;
        if (frame_valid !== 1'b0 || frame_count !== 16'd3) begin
            n_err++; $display("FAIL stall_drain fv=%b cnt=%0d exp 0/3", frame_valid, frame_count);
        end
    endtask

    task automatic test_resync();
        int pulses;
        logic [FW-1:0] exp;
        pulses = 0;
        frame_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            send(8'h40 + 8'(k), k == 0);
            if (sync_err === 1'b1) pulses++;
        end
        send(8'hAA, 1'b1);
        n_cmp++;
        if (sync_err !== 1'b1) begin n_err++; $display("FAIL resync_pulse got=%b exp=1", sync_err); end
        if (sync_err === 1'b1) pulses++;
        for (int k = 1; k < NP; k++) begin
            send(8'h50 + 8'(k), 1'b0);
            if (sync_err === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL resync_pulse_count got=%0d exp=1", pulses); end
        exp = frame_ramp(8'h50);
        exp[7:0] = 8'hAA;
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== exp) begin
            n_err++; $display("FAIL resync_data fv=%b got=%h exp=%h", frame_valid, frame_data, exp);
        end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        n_cmp++;
        if (frame_count !== 16'd4) begin n_err++; $display("FAIL resync_count got=%0d exp=4", frame_count); end
    endtask

    task automatic test_back_to_back();
        int nframes;
        int ready_low;
        logic exp_fv;
        nframes = 0;
        ready_low = 0;
        do_reset();
        frame_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            pixel_in    = 8'(i);
            pixel_sof   = (i % NP) == 0;
            pixel_valid = 1'b1;
            step();
            if (pixel_ready !== 1'b1) ready_low++;
            exp_fv = (i % NP) == NP - 1;
            n_cmp++;
            if (frame_valid !== exp_fv) begin
                n_err++; $display("FAIL b2b_fv cycle=%0d got=%b exp=%b", i, frame_valid, exp_fv);
            end
            if (frame_valid === 1'b1) begin
                n_cmp++;
                if (frame_data !== frame_ramp(8'((nframes * NP) & 255))) begin
                    n_err++; $display("FAIL b2b_data frame=%0d got=%h", nframes, frame_data);
                end
                nframes++;
            end
        end
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        frame_ready = 1'b0;
        n_cmp++;
        if (ready_low != 0) begin n_err++; $display("FAIL b2b_ready_low got=%0d exp=0", ready_low); end
        n_cmp++;
        if (nframes != 4 || frame_count !== 16'd4) begin
            n_err++; $display("FAIL b2b_count frames=%0d cnt=%0d exp 4/4", nframes, frame_count);
        end
    endtask

    task automatic test_reset_in_stall();
        do_reset();
        frame_ready = 1'b0;
        send_ramp(8'h01);
        send_ramp(8'h60);
        n_cmp++;
        if (pixel_ready !== 1'b0) begin n_err++; $display("FAIL rststall_enter got=%b exp=0", pixel_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (frame_valid !== 1'b0 || frame_data !== '0 || frame_count !== 16'd0 || pixel_ready !== 1'b1) begin
            n_err++; $display("FAIL rststall_state fv=%b data0=%b cnt=%0d rdy=%b exp 0/1/0/1",
                              frame_valid, frame_data == '0, frame_count, pixel_ready);
        end
        send_ramp(8'h20);
        n_cmp++;
        if (frame_valid !== 1'b1 || frame_data !== frame_ramp(8'h20)) begin
            n_err++; $display("FAIL rststall_frame fv=%b got=%h exp=%h", frame_valid, frame_data, frame_ramp(8'h20));
        end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        n_cmp++;
        if (frame_count !== 16'd1) begin n_err++; $display("FAIL rststall_count got=%0d exp=1", frame_count); end
    endtask

    task automatic test_random_backpressure();
        int tx_f, tx_k, rx_f;
        logic prev_hold;
        logic [FW-1:0] prev_data;
        logic [FW-1:0] cur;
        do_reset();
        tx_f = 0; tx_k = 0; rx_f = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 6000 && rx_f < 10; c++) begin
            if (prev_hold) begin
                n_cmp++;
                if (frame_valid !== 1'b1 || frame_data !== prev_data) begin
                    n_err++; $display("FAIL rand_stable cycle=%0d fv=%b got=%h exp=%h", c, frame_valid, frame_data, prev_data);
                end
            end
            frame_ready = 1'($urandom_range(0, 1));
            pixel_valid = (tx_f < 10) && ($urandom_range(0, 1) == 1);
            cur         = frame_rand(tx_f);
            pixel_in    = cur[tx_k*PW +: PW];
            pixel_sof   = tx_k == 0;
            if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
                n_cmp++;
                if (frame_data !== frame_rand(rx_f)) begin
                    n_err++; $display("FAIL rand_frame idx=%0d got=%h exp=%h", rx_f, frame_data, frame_rand(rx_f));
                end
                rx_f++;
            end
            prev_hold = frame_valid && !frame_ready;
            prev_data = frame_data;
            if (pixel_valid && pixel_ready) begin
                if (tx_k == NP - 1) begin
                    tx_k = 0;
                    tx_f++;
                end else begin
                    tx_k++;
                end
            end
            step();
        end
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        frame_ready = 1'b0;
        n_cmp++;
        if (rx_f != 10) begin n_err++; $display("FAIL rand_timeout received=%0d exp=10", rx_f); end
        n_cmp++;
        if (frame_count !== 16'd10) begin n_err++; $display("FAIL rand_count got=%0d exp=10", frame_count); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_resync();
        test_back_to_back();
        test_reset_in_stall();
        test_random_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
